// File: rtl/ifid_stage.sv
// ifid_stage: fetch-side program counter and IF/ID pipeline register for a
// 5-stage MIPS pipeline. Resolves beq/bne/j in ID and redirects fetch,
// squashing the single wrong-path instruction fetched behind the branch.
//
// Handshake: there is no valid/ready pair here. stall is a hold request from
// the hazard unit, sampled on the rising edge; while it is high every register
// keeps its value and no redirect is taken. if_id_valid marks whether IF/ID
// holds a real instruction (0 = bubble); a bubble never redirects.
module ifid_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        beq,
    input  logic        bne,
    input  logic        jump,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] mem_fwd_data,
    input  logic        forward1,
    input  logic        forward2,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    logic [31:0] r_pc;
    logic [31:0] r_if_id_instr;
    logic [31:0] r_if_id_pc4;
    logic        r_if_id_valid;

    logic [31:0] w_pc4;
    logic [31:0] w_op_a;
    logic [31:0] w_op_b;
    logic        w_ops_equal;
    logic        w_id_active;
    logic        w_take_br;
    logic        w_take_j;
    logic        w_redirect;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_redirect_pc;

    // Branch compare, target calculation and redirect decision in ID.
    always_comb begin
        w_pc4       = r_pc + 32'd4;
        w_op_a      = forward1 ? mem_fwd_data : rs_data;
        w_op_b      = forward2 ? mem_fwd_data : rt_data;
        w_ops_equal = (w_op_a == w_op_b);
        // A bubble or a stalled ID stage never acts on its decode signals.
        w_id_active = r_if_id_valid & ~stall;
        w_take_br   = w_id_active & ((beq & w_ops_equal) | (bne & ~w_ops_equal));
        w_take_j    = w_id_active & jump;
        w_redirect  = w_take_br | w_take_j;
        // Offset arithmetic is modulo 2^32, so backward branches may wrap.
        w_br_target = r_if_id_pc4
                    + {{14{r_if_id_instr[15]}}, r_if_id_instr[15:0], 2'b00};
        w_j_target  = {r_if_id_pc4[31:28], r_if_id_instr[25:0], 2'b00};
        // Jump beats a simultaneously decoded branch.
        if (w_take_j) begin
            w_redirect_pc = w_j_target;
        end else if (w_take_br) begin
            w_redirect_pc = w_br_target;
        end else begin
            w_redirect_pc = w_pc4;
        end
    end

    // PC and IF/ID update: reset > stall > redirect (squash) > sequential.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_if_id_instr <= 32'h0;
            r_if_id_pc4   <= 32'h0;
            r_if_id_valid <= 1'b0;
        end else if (stall) begin
            r_pc          <= r_pc;
            r_if_id_instr <= r_if_id_instr;
            r_if_id_pc4   <= r_if_id_pc4;
            r_if_id_valid <= r_if_id_valid;
        end else if (w_redirect) begin
            r_pc          <= w_redirect_pc;
            r_if_id_instr <= 32'h0;
            r_if_id_pc4   <= 32'h0;
            r_if_id_valid <= 1'b0;
        end else begin
            r_pc          <= w_pc4;
            r_if_id_instr <= imem_rdata;
            r_if_id_pc4   <= w_pc4;
            r_if_id_valid <= 1'b1;
        end
    end

    // Registered state and redirect decision drive the outputs directly.
    always_comb begin
        imem_addr   = r_pc;
        if_id_instr = r_if_id_instr;
        if_id_pc4   = r_if_id_pc4;
        if_id_valid = r_if_id_valid;
        redirect    = w_redirect;
        redirect_pc = w_redirect_pc;
    end

endmodule

// File: tb/tb_ifid_stage.sv
// Directed bench for ifid_stage: straight-line fetch, taken beq, forwarded
// bne, jump-over-branch priority, bubble ignore, stall over a branch, branch
// and sequential wrap, jump across a 256MB region, async reset mid-redirect.
module tb_ifid_stage;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        beq;
    logic        bne;
    logic        jump;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] mem_fwd_data;
    logic        forward1;
    logic        forward2;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        f_beq;
    logic        f_bne;
    logic        f_jump;
    logic [31:0] mem [0:127];

    int n_cmp;
    int n_err;

    ifid_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .beq          (beq),
        .bne          (bne),
        .jump         (jump),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .mem_fwd_data (mem_fwd_data),
        .forward1     (forward1),
        .forward2     (forward2),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc)
    );

    // Clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: small array plus a few far-away words.
    assign imem_rdata = (imem_addr == 32'hFFFF_FFFC) ? 32'h0BFF_FFFF :
                        (imem_addr == 32'h0FFF_FFFC) ? 32'h0000_0000 :
                        (imem_addr == 32'h1000_0000) ? 32'h0800_0040 :
                        mem[imem_addr[8:2]];

    // ID decode of the opcode in IF/ID, plus forced decode for directed cases.
    assign beq  = (if_id_instr[31:26] == 6'd4) | f_beq;
    assign bne  = (if_id_instr[31:26] == 6'd5) | f_bne;
    assign jump = (if_id_instr[31:26] == 6'd2) | f_jump;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        settle();
        check_eq("rst_pc", imem_addr, 32'h0);
        check_eq("rst_instr", if_id_instr, 32'h0);
        check_eq("rst_pc4", if_id_pc4, 32'h0);
        check_eq("rst_valid", {31'b0, if_id_valid}, 32'h0);
        check_eq("rst_redirect", {31'b0, redirect}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        stall = 1'b0;
        f_beq = 1'b0;
        f_bne = 1'b0;
        f_jump = 1'b0;
        rs_data = 32'd5;
        rt_data = 32'd5;
        mem_fwd_data = 32'd0;
        forward1 = 1'b0;
        forward2 = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[0] = 32'h0022_1820;   // A
        mem[1] = 32'h0043_2020;   // B
        mem[2] = 32'h0064_2820;   // C
        mem[3] = 32'h0085_3020;   // D
        mem[4] = 32'h1000_0003;   // 0x10: beq imm=3 -> 0x20
        mem[5] = 32'h00A6_3820;   // 0x14: wrong path
        mem[8] = 32'h0000_0010;   // 0x20: F
        mem[9] = 32'h0000_0008;   // 0x24: G

        // Phase 1: reset, straight-line, taken beq, forwarded bne
        do_reset();
        tick();
        check_eq("e1_instr", if_id_instr, 32'h0022_1820);
        check_eq("e1_pc4", if_id_pc4, 32'h4);
        check_eq("e1_valid", {31'b0, if_id_valid}, 32'h1);
        check_eq("e1_pc", imem_addr, 32'h4);
        tick();
        check_eq("e2_instr", if_id_instr, 32'h0043_2020);
        check_eq("e2_pc4", if_id_pc4, 32'h8);
        tick();
        check_eq("e3_instr", if_id_instr, 32'h0064_2820);
        check_eq("e3_pc4", if_id_pc4, 32'hC);
        tick();
        tick();
        check_eq("beq_in_id", if_id_instr, 32'h1000_0003);
        check_eq("beq_redirect", {31'b0, redirect}, 32'h1);
        check_eq("beq_target", redirect_pc, 32'h20);
        tick();
        check_eq("beq_pc", imem_addr, 32'h20);
        check_eq("beq_squash_valid", {31'b0, if_id_valid}, 32'h0);
        check_eq("beq_squash_instr", if_id_instr, 32'h0);
        check_eq("bubble_no_redirect", {31'b0, redirect}, 32'h0);
        tick();
        check_eq("target_instr", if_id_instr, 32'h0000_0010);
        check_eq("target_pc4", if_id_pc4, 32'h24);

        rs_data = 32'd7;
        rt_data = 32'd7;
        mem_fwd_data = 32'd9;
        f_bne = 1'b1;
        settle();
        check_eq("bne_nofwd_redirect", {31'b0, redirect}, 32'h0);
        check_eq("bne_nofwd_rpc", redirect_pc, 32'h28);
        tick();
        check_eq("bne_nofwd_pc", imem_addr, 32'h28);
        check_eq("bne_nofwd_instr", if_id_instr, 32'h0000_0008);
        forward1 = 1'b1;
        f_jump = 1'b1;
        settle();
        check_eq("jump_wins_rpc", redirect_pc, 32'h20);
        f_jump = 1'b0;
        settle();
        check_eq("bne_fwd_redirect", {31'b0, redirect}, 32'h1);
        check_eq("bne_fwd_target", redirect_pc, 32'h48);
        forward2 = 1'b1;
        settle();
        check_eq("bne_fwd2_equal", {31'b0, redirect}, 32'h0);
        forward2 = 1'b0;
        settle();
        tick();
        check_eq("bne_fwd_pc", imem_addr, 32'h48);
        check_eq("bne_fwd_valid", {31'b0, if_id_valid}, 32'h0);
        f_jump = 1'b1;
        settle();
        check_eq("bubble_ignores_jump", {31'b0, redirect}, 32'h0);
        f_jump = 1'b0;
        f_bne = 1'b0;
        forward1 = 1'b0;
        rs_data = 32'd5;
        rt_data = 32'd5;

        // Phase 2: stall over a taken beq
        do_reset();
        repeat (5) tick();
        stall = 1'b1;
        settle();
        check_eq("stall_redirect0", {31'b0, redirect}, 32'h0);
        tick();
        check_eq("stall1_pc", imem_addr, 32'h14);
        check_eq("stall1_instr", if_id_instr, 32'h1000_0003);
        check_eq("stall1_valid", {31'b0, if_id_valid}, 32'h1);
        tick();
        check_eq("stall2_pc", imem_addr, 32'h14);
        check_eq("stall2_pc4", if_id_pc4, 32'h14);
        check_eq("stall2_redirect", {31'b0, redirect}, 32'h0);
        stall = 1'b0;
        settle();
        check_eq("unstall_redirect", {31'b0, redirect}, 32'h1);
        check_eq("unstall_target", redirect_pc, 32'h20);
        tick();
        check_eq("unstall_pc", imem_addr, 32'h20);
        check_eq("unstall_valid", {31'b0, if_id_valid}, 32'h0);
        tick();
        check_eq("unstall_instr", if_id_instr, 32'h0000_0010);

        // Phase 3: backward branch wrap, sequential wrap, jumps, async reset
        mem[0] = 32'h1000_FFFE;   // beq imm=-2 at 0 -> 0xFFFFFFFC
        do_reset();
        tick();
        check_eq("wrap_br_target", redirect_pc, 32'hFFFF_FFFC);
        tick();
        check_eq("wrap_br_pc", imem_addr, 32'hFFFF_FFFC);
        tick();
        check_eq("seq_wrap_pc", imem_addr, 32'h0);
        check_eq("seq_wrap_pc4", if_id_pc4, 32'h0);
        check_eq("seq_wrap_instr", if_id_instr, 32'h0BFF_FFFF);
        check_eq("j1_target", redirect_pc, 32'h0FFF_FFFC);
        tick();
        check_eq("j1_pc", imem_addr, 32'h0FFF_FFFC);
        tick();
        check_eq("region_pc4", if_id_pc4, 32'h1000_0000);
        tick();
        check_eq("j2_pc4", if_id_pc4, 32'h1000_0004);
        check_eq("j2_redirect", {31'b0, redirect}, 32'h1);
        check_eq("j2_target", redirect_pc, 32'h1000_0100);
        #1;
        reset = 1'b1;
        settle();
        check_eq("arst_pc", imem_addr, 32'h0);
        check_eq("arst_valid", {31'b0, if_id_valid}, 32'h0);
        check_eq("arst_redirect", {31'b0, redirect}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check_eq("arst_no_target_pc", imem_addr, 32'h4);
        check_eq("arst_fetch_instr", if_id_instr, 32'h1000_FFFE);

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ifid_stage.md
# ifid_stage

Fetch stage and IF/ID pipeline register for the 5-stage MIPS pipeline. It holds the PC, presents it to instruction memory, and latches the fetched instruction and PC+4 into IF/ID. It resolves beq/bne and j in ID, using forward1/forward2 from hazarddetection to select compare operands, and redirects fetch. It obeys the hazard unit's stall and squashes the wrong-path instruction on every redirect.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- imem_addr  out  32  current PC to instruction memory; equals pc register
- imem_rdata  in  32  instruction at imem_addr, combinational read, valid in same cycle
- stall  in  1  from hazarddetection; hold PC and IF/ID
- beq  in  1  ID-stage decode: branch-if-equal
- bne  in  1  ID-stage decode: branch-if-not-equal
- jump  in  1  ID-stage decode: j
- rs_data  in  32  register-file read of IF/ID rs
- rt_data  in  32  register-file read of IF/ID rt
- mem_fwd_data  in  32  EX/MEM ALU result for branch forwarding
- forward1  in  1  select mem_fwd_data for compare operand A
- forward2  in  1  select mem_fwd_data for compare operand B
- if_id_instr  out  32  registered instruction in ID
- if_id_pc4  out  32  registered PC+4 of that instruction
- if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble)
- redirect  out  1  combinational: branch taken or jump this cycle
- redirect_pc  out  32  combinational target when redirect=1, else pc+4

## Operation
- State: pc (32), if_id_instr (32), if_id_pc4 (32), if_id_valid (1).
- Operand A = forward1 ? mem_fwd_data : rs_data; B = forward2 ? mem_fwd_data : rt_data.
- take_br = if_id_valid & ~stall & ((beq & A==B) | (bne & A!=B)).
- take_j = if_id_valid & ~stall & jump.
- redirect = take_br | take_j.
- Branch target = if_id_pc4 + (sign_extend(if_id_instr[15:0]) << 2), modulo 2^32.
- Jump target = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00}.
- If jump and beq/bne are both asserted, the jump wins (decode error tolerance).
- Next-state priority per edge: reset > stall > redirect > sequential.
- stall: pc, if_id_instr, if_id_pc4 and if_id_valid all hold; no redirect is taken. The branch is re-evaluated each cycle until stall drops.
- redirect: pc <= target; if_id_instr <= 32'h0; if_id_pc4 <= 0; if_id_valid <= 0. The fetched wrong-path instruction is squashed.
- sequential: pc <= pc+4 (wraps 32'hFFFF_FFFC -> 0); if_id_instr <= imem_rdata; if_id_pc4 <= pc+4; if_id_valid <= 1.
- If if_id_valid=0, beq/bne/jump are ignored, so the bubble never redirects.
- Branch and jump have no delay slot; wrong-path penalty is 1 cycle.

## Timing
- Reset (async, any time including mid-redirect): pc=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0. Combinational outputs follow: imem_addr=RESET_PC, redirect=0.
- First edge after reset release, with no stall: IF/ID = mem[RESET_PC], valid=1, pc=RESET_PC+4.
- Redirect is decided combinationally in the ID cycle. Fetch from the target occurs the next cycle, and the target instruction reaches ID 2 cycles after the branch was in ID.
- stall takes effect on the same edge it is sampled high. The edge after stall drops resumes normal operation with no lost or duplicated instruction.
- imem_addr changes only on clock edges or on reset assertion.

## Test plan
- Reset and straight-line: RESET_PC=0, mem[0,4,8]=A,B,C, no branches. Expect IF/ID instr A,B,C on edges 1,2,3, pc4 4,8,12, valid=1.
- Taken beq: instruction at 0x10 is beq with imm=3, rs_data=rt_data=5. Expect redirect=1, redirect_pc=0x20. Next edge: pc=0x20, valid=0. Edge after: IF/ID instr = mem[0x20].
- Forwarded bne: rs_data=7, rt_data=7, mem_fwd_data=9, forward1=1. Expect taken; with forward1=0, expect not taken and pc advances by 4.
- Stall over branch: hold stall=1 for 2 cycles while a taken beq is in ID. Expect pc and IF/ID unchanged and redirect=0 during the stall; redirect on the first cycle stall=0.
- Jump and wrap: j with target field 0x0000040 at pc4 0x1000_0004. Expect redirect_pc=0x1000_0100. Separately, pc=0xFFFF_FFFC sequential wraps to 0.
- Async reset mid-redirect: assert reset between edges while redirect=1. Expect immediate pc=RESET_PC, valid=0, and no target fetched.
